// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache with a small store buffer and one outstanding miss.
// Optional macro DCACHE_STFWD_EN: a miss bypasses the store-buffer drain unless a buffered store hits its line.
module dcache_ctrl #(
  parameter int DC_LINES    = 32,
  parameter int DC_IDX_BITS = 5,
  parameter int STB_DEPTH   = 4,
  parameter int STB_BITS    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsq_rd_mem,
  input  logic [63:0] lsq_addr,
  input  logic [6:0]  lsq_pr_idx,
  input  logic [4:0]  lsq_ar_idx,
  input  logic        lsq_wr_mem,
  input  logic [63:0] lsq_st_addr,
  input  logic [63:0] lsq_st_value,
  output logic        dcache_avail,
  output logic        dcache_st_full,
  output logic        dc_cdb_complete,
  output logic [6:0]  dc_cdb_prf_pr_idx,
  output logic [4:0]  dc_cdb_ar_idx,
  output logic        dc_prf_wr_enable,
  output logic [63:0] dc_prf_value,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam int TAG_BITS = 64 - DC_IDX_BITS - 3;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REQ, S_WAIT} state_t;

  state_t state_reg, state_next;

  logic [DC_LINES-1:0] valid_reg;
  logic [TAG_BITS-1:0] line_tag_reg  [DC_LINES];
  logic [63:0]         line_data_reg [DC_LINES];

  logic [60:0] stb_line_reg [STB_DEPTH];
  logic [63:0] stb_data_reg [STB_DEPTH];
  logic [STB_BITS-1:0] head_reg, tail_reg;
  logic [STB_BITS:0]   count_reg;

  logic [60:0] miss_line_reg;
  logic [6:0]  miss_pr_reg;
  logic [4:0]  miss_ar_reg;
  logic [3:0]  wait_tag_reg;
  logic        dirty_reg;

  logic        complete_reg;
  logic [6:0]  pr_reg;
  logic [4:0]  ar_reg;
  logic [63:0] value_reg;

  logic [DC_IDX_BITS-1:0] ld_idx, st_idx, miss_idx;
  logic [TAG_BITS-1:0]    ld_tag, st_tag, miss_tag;
  logic ld_hit, hit_accept, miss_accept, need_drain;
  logic stb_empty, stb_full, push, pop, st_hit;
  logic fill, fill_install, st_to_miss, enter_req_drain;
  logic unused_bits;

  assign ld_idx   = lsq_addr[DC_IDX_BITS+2:3];
  assign ld_tag   = lsq_addr[63:DC_IDX_BITS+3];
  assign st_idx   = lsq_st_addr[DC_IDX_BITS+2:3];
  assign st_tag   = lsq_st_addr[63:DC_IDX_BITS+3];
  assign miss_idx = miss_line_reg[DC_IDX_BITS-1:0];
  assign miss_tag = miss_line_reg[60:DC_IDX_BITS];
  assign unused_bits = ^{lsq_addr[2:0], lsq_st_addr[2:0]};

  assign ld_hit     = valid_reg[ld_idx] && (line_tag_reg[ld_idx] == ld_tag);
  assign hit_accept = (state_reg == S_IDLE) && lsq_rd_mem && ld_hit;

  assign stb_empty = (count_reg == '0);
  assign stb_full  = (count_reg == (STB_BITS+1)'(STB_DEPTH));
  assign push      = lsq_wr_mem && !stb_full;
  assign pop       = !stb_empty && (state_reg != S_REQ) && (mem2proc_response != 4'd0);
  assign st_hit    = push && valid_reg[st_idx] && (line_tag_reg[st_idx] == st_tag);

  // A store to the in-flight line makes the returning fill stale, even in the fill cycle itself.
  assign st_to_miss   = push && (lsq_st_addr[63:3] == miss_line_reg) &&
                        ((state_reg == S_REQ) || (state_reg == S_WAIT));
  assign fill         = (state_reg == S_WAIT) && (mem2proc_tag != 4'd0) && (mem2proc_tag == wait_tag_reg);
  assign fill_install = fill && !(dirty_reg || st_to_miss);

`ifdef DCACHE_STFWD_EN
  logic [STB_DEPTH-1:0] stb_match;
  genvar gi;
  generate
    for (gi = 0; gi < STB_DEPTH; gi++) begin : g_stb_cmp
      logic [STB_BITS-1:0] slot_ofs;
      assign slot_ofs      = STB_BITS'(gi) - head_reg;
      assign stb_match[gi] = ({1'b0, slot_ofs} < count_reg) && (stb_line_reg[gi] == lsq_addr[63:3]);
    end
  endgenerate
  assign need_drain = |stb_match;
`else
  assign need_drain = !stb_empty;
`endif

  always_comb begin
    state_next       = state_reg;
    miss_accept      = 1'b0;
    enter_req_drain  = 1'b0;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (state_reg)
      S_IDLE: begin
        if (lsq_rd_mem && !ld_hit) begin
          miss_accept     = 1'b1;
          enter_req_drain = 1'b1;
          state_next      = need_drain ? S_DRAIN : S_REQ;
        end
      end
      S_DRAIN: begin
        if (stb_empty) begin
          enter_req_drain = 1'b1;
          state_next      = S_REQ;
        end
      end
      S_REQ:  if (mem2proc_response != 4'd0) state_next = S_WAIT;
      S_WAIT: if (fill) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // The miss request owns the bus in REQ; the store drain uses it otherwise.
    if (state_reg == S_REQ) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = {miss_line_reg, 3'b000};
    end else if (!stb_empty) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = {stb_line_reg[head_reg], 3'b000};
      proc2mem_data    = stb_data_reg[head_reg];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (fill_install) begin
      valid_reg[miss_idx] <= 1'b1;
    end
  end

  // Fill is written after the store update so a fill replacing a different line wins.
  always_ff @(posedge clock) begin
    if (st_hit) line_data_reg[st_idx] <= lsq_st_value;
    if (fill_install) begin
      line_data_reg[miss_idx] <= mem2proc_data;
      line_tag_reg[miss_idx]  <= miss_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      stb_line_reg[tail_reg] <= lsq_st_addr[63:3];
      stb_data_reg[tail_reg] <= lsq_st_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_line_reg <= '0;
      miss_pr_reg   <= '0;
      miss_ar_reg   <= '0;
      wait_tag_reg  <= '0;
      dirty_reg     <= 1'b0;
    end else begin
      if (miss_accept) begin
        miss_line_reg <= lsq_addr[63:3];
        miss_pr_reg   <= lsq_pr_idx;
        miss_ar_reg   <= lsq_ar_idx;
      end
      if (state_reg == S_REQ && mem2proc_response != 4'd0) wait_tag_reg <= mem2proc_response;
      // Clear on entry to REQ/DRAIN, but keep a store to the same line pushed on that very edge.
      if (enter_req_drain) begin
        dirty_reg <= push && (lsq_st_addr[63:3] == (miss_accept ? lsq_addr[63:3] : miss_line_reg));
      end else if (st_to_miss) begin
        dirty_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      complete_reg <= 1'b0;
      pr_reg       <= '0;
      ar_reg       <= '0;
      value_reg    <= '0;
    end else begin
      complete_reg <= 1'b0;
      pr_reg       <= '0;
      ar_reg       <= '0;
      value_reg    <= '0;
      if (hit_accept) begin
        complete_reg <= 1'b1;
        pr_reg       <= lsq_pr_idx;
        ar_reg       <= lsq_ar_idx;
        value_reg    <= line_data_reg[ld_idx];
      end else if (fill) begin
        complete_reg <= 1'b1;
        pr_reg       <= miss_pr_reg;
        ar_reg       <= miss_ar_reg;
        value_reg    <= mem2proc_data;
      end
    end
  end

  assign dcache_avail      = (state_reg == S_IDLE);
  assign dcache_st_full    = stb_full;
  assign dc_cdb_complete   = complete_reg;
  assign dc_prf_wr_enable  = complete_reg;
  assign dc_cdb_prf_pr_idx = pr_reg;
  assign dc_cdb_ar_idx     = ar_reg;
  assign dc_prf_value      = value_reg;

endmodule
